serial_writeback: RTL and testbench
===================================

SERIAL_WRITEBACK -- requirements
Module: serial_writeback

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 8, giving serial word length in bits.
REQ-002 SHALL have input clk, 1 bit, rising-edge clock.
REQ-003 SHALL have input rstn, 1 bit; reset rstn, synchronous, active-low; clock clk.
REQ-004 SHALL have input start, 1 bit, single-cycle request to begin capturing one serial result word.
REQ-005 SHALL have input wb_en, 1 bit, high if the current instruction writes a register; sampled only on an accepted start.
REQ-006 SHALL have input result_bit, 1 bit, serial ALU result bit, LSB first, valid on every cycle reg_shift_en is high.
REQ-007 SHALL have input flush, 1 bit, synchronous abort of the current operation.
REQ-008 SHALL have output reg_shift_en, 1 bit, shift-enable to the register file, high for exactly REG_WIDTH consecutive cycles per operation.
REQ-009 SHALL have output bit_count, 3 bits, index of the bit captured in the current cycle.
REQ-010 SHALL have output regs_parallel_out, REG_WIDTH bits, assembled result word, fed to the register file parallel input.
REQ-011 SHALL have output reg_store_en, 1 bit, one-cycle parallel-store strobe to the register file.
REQ-012 SHALL have output busy, 1 bit, high in any state other than IDLE.
REQ-013 SHALL have output done, 1 bit, one-cycle completion pulse.

Function
REQ-014 SHALL implement the FSM states IDLE, SHIFT, STORE and DONE, with every output decoded from registered state only (Moore).
REQ-015 IDLE: start=1 SHALL accept the request, latch wb_en into wb_q, clear bit_count to 0, and move to SHIFT on the next edge; start=0 SHALL hold IDLE.
REQ-016 SHIFT: reg_shift_en SHALL be 1, the accumulator SHALL update as acc <= {result_bit, acc[REG_WIDTH-1:1]}, and bit_count SHALL increment by 1 on each cycle.
REQ-017 SHIFT SHALL exit to STORE on the edge where bit_count == REG_WIDTH-1, giving exactly REG_WIDTH shift cycles; bit_count SHALL wrap to 0 on that edge.
REQ-018 STORE: reg_store_en SHALL equal wb_q for exactly one cycle, reg_shift_en SHALL be 0, and the next state SHALL be DONE.
REQ-019 DONE: done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-020 reg_shift_en and reg_store_en SHALL never be high in the same cycle.
REQ-021 regs_parallel_out SHALL equal acc and SHALL hold its value in STORE, DONE and IDLE until the next accepted start's first shift.
REQ-022 After capture, acc[i] SHALL equal the result_bit presented on shift cycle i, for i = 0..REG_WIDTH-1.
REQ-023 start asserted while busy=1 SHALL be ignored; it SHALL NOT be queued and SHALL NOT relatch wb_en.
REQ-024 start asserted in the DONE cycle SHALL be ignored; a new request is accepted only in IDLE.
REQ-025 flush=1 in any state SHALL force IDLE on the next edge, clear bit_count, and suppress reg_store_en and done for the aborted operation; acc SHALL keep its value.
REQ-026 flush and start high together in IDLE SHALL resolve with flush winning, so the request is not accepted.
REQ-027 Total latency from the accepted start edge SHALL be: first shift cycle at +1, STORE at +REG_WIDTH+1, done at +REG_WIDTH+2, IDLE at +REG_WIDTH+3.

Reset
REQ-028 rstn=0 at a clock edge SHALL force state IDLE, bit_count=0, acc=0 and wb_q=0, overriding start and flush.
REQ-029 While in reset, every output SHALL read 0: reg_shift_en, reg_store_en, busy, done, bit_count and regs_parallel_out.
REQ-030 Reset asserted mid-SHIFT or in STORE SHALL abort with no reg_store_en pulse, and the block SHALL accept a new start on the first cycle after rstn returns high.

Verification
REQ-031 start with wb_en=1 and result_bit sequence 1,0,1,1,0,0,1,0 (LSB first) -> reg_shift_en high 8 cycles, bit_count 0..7, STORE cycle with reg_store_en=1 and regs_parallel_out=8'h4D, done pulse, then IDLE.
REQ-032 Same stimulus with wb_en=0 -> regs_parallel_out=8'h4D, reg_store_en stays 0 throughout, done still pulses at start+10.
REQ-033 start repeated at shift cycles 3 and 7 and in the DONE cycle -> no extra shift cycles, a single store and a single done, wb_q unchanged.
REQ-034 flush at shift cycle 4 -> IDLE next cycle, no reg_store_en, no done, busy=0; the next start runs a clean 8-cycle capture.
REQ-035 rstn=0 during STORE -> reg_store_en drops that edge, all outputs 0, acc=0; start one cycle after release is accepted.
REQ-036 Back-to-back starts issued on each first IDLE cycle for 3 words 8'hFF, 8'h00, 8'hA5 -> each word captured exactly, 11-cycle period between starts, and reg_shift_en/reg_store_en never overlap.

Source files
------------

// File: rtl/serial_writeback_if.sv
// serial_writeback_if: handshake and result bus between the issue stage, the serial ALU and the register file
interface serial_writeback_if #(parameter int REG_WIDTH = 8);
  logic                 start;
  logic                 wb_en;
  logic                 result_bit;
  logic                 flush;
  logic                 reg_shift_en;
  logic [2:0]           bit_count;
  logic [REG_WIDTH-1:0] regs_parallel_out;
  logic                 reg_store_en;
  logic                 busy;
  logic                 done;
  modport master (
    output start, wb_en, result_bit, flush,
    input  reg_shift_en, bit_count, regs_parallel_out, reg_store_en, busy, done
  );
  modport slave (
    input  start, wb_en, result_bit, flush,
    output reg_shift_en, bit_count, regs_parallel_out, reg_store_en, busy, done
  );
endinterface

// File: rtl/serial_writeback.sv
// serial_writeback: captures one LSB-first serial result word and strobes it into the register file
module serial_writeback #(parameter int REG_WIDTH = 8) (
  input logic               clk,
  input logic               rstn,
  serial_writeback_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, STORE, DONE} state_t;
  state_t               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [REG_WIDTH-1:0] acc_q, acc_d;
  logic                 wb_q, wb_d;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      wb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      wb_q    <= wb_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    wb_d    = wb_q;
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          wb_d    = bus.wb_en;
        end
        SHIFT: begin
          acc_d   = {bus.result_bit, acc_q[REG_WIDTH-1:1]};
          state_d = (cnt_q == 3'(REG_WIDTH-1)) ? STORE : SHIFT;
          cnt_d   = (cnt_q == 3'(REG_WIDTH-1)) ? 3'd0 : cnt_q + 3'd1;
        end
        STORE:   state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end
  // outputs are state decodes, forced low while reset is held
  assign bus.reg_shift_en      = rstn && (state_q == SHIFT);
  assign bus.reg_store_en      = rstn && (state_q == STORE) && wb_q;
  assign bus.done              = rstn && (state_q == DONE);
  assign bus.busy              = rstn && (state_q != IDLE);
  assign bus.bit_count         = rstn ? cnt_q : 3'd0;
  assign bus.regs_parallel_out = rstn ? acc_q : '0;
endmodule

// File: tb/tb_serial_writeback.sv
// tb_serial_writeback: timeline model of one capture plus directed scenarios with literal expectations
module tb_serial_writeback;
  localparam int W = 8;
  logic clk = 0;
  logic rstn = 0;
  serial_writeback_if #(.REG_WIDTH(W)) bus();
  serial_writeback #(.REG_WIDTH(W)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int k = 0;
  logic m_wb = 0;
  logic [W-1:0] m_acc = '0;
  int shift_n = 0, store_n = 0, done_n = 0, ovl_n = 0, cyc = 0;
  int s0, t0, d0;
  int dt[$];
  bit cmp_en = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask
  // k counts cycles since the accepted start: 1..W shift, W+1 store, W+2 done
  always @(posedge clk) begin
    cyc++;
    if (!rstn) begin
      k = 0; m_wb = 0; m_acc = '0;
    end else if (bus.flush) k = 0;
    else if (k == 0) begin
      if (bus.start) begin k = 1; m_wb = bus.wb_en; end
    end else begin
      if (k <= W) m_acc = {bus.result_bit, m_acc[W-1:1]};
      k = (k == W + 2) ? 0 : k + 1;
    end
  end
  always @(negedge clk) begin
    if (bus.reg_shift_en) shift_n++;
    if (bus.reg_store_en) store_n++;
    if (bus.done) begin done_n++; dt.push_back(cyc); end
    if (bus.reg_shift_en && bus.reg_store_en) ovl_n++;
    if (cmp_en) begin
      chk("shift_en", bus.reg_shift_en, rstn && k >= 1 && k <= W);
      chk("bit_count", bus.bit_count, (rstn && k >= 1 && k <= W) ? k - 1 : 0);
      chk("store_en", bus.reg_store_en, rstn && k == W + 1 && m_wb);
      chk("done", bus.done, rstn && k == W + 2);
      chk("busy", bus.busy, rstn && k != 0);
      chk("parallel_out", bus.regs_parallel_out, rstn ? m_acc : '0);
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic snap();
    s0 = shift_n; t0 = store_n; d0 = done_n;
  endtask
  task automatic deltas(input string n, input int s, input int t, input int d);
    chk({n, "_shifts"}, shift_n - s0, s);
    chk({n, "_stores"}, store_n - t0, t);
    chk({n, "_dones"}, done_n - d0, d);
  endtask
  // mode 0 plain, 1 stray starts at shift 3/7 and in DONE, 2 flush at shift 4, 3 reset in STORE
  task automatic op(input logic [W-1:0] w, input logic wb, input int mode);
    bus.start = 1; bus.wb_en = wb; tick();
    for (int i = 0; i < W; i++) begin
      bus.start = (mode == 1 && (i == 3 || i == 7));
      bus.wb_en = bus.start ? ~wb : 1'b0;
      bus.result_bit = w[i];
      bus.flush = (mode == 2 && i == 4);
      tick();
      if (bus.flush) begin bus.flush = 0; bus.start = 0; bus.result_bit = 0; return; end
    end
    bus.start = 0; bus.wb_en = 0; bus.result_bit = 0;
    if (mode == 3) rstn = 0;
    tick();
    rstn = 1;
    if (mode == 3) return;
    bus.start = (mode == 1); bus.wb_en = bus.start ? ~wb : 1'b0;
    tick();
    bus.start = 0; bus.wb_en = 0;
  endtask
  initial begin
    bus.start = 0; bus.wb_en = 0; bus.result_bit = 0; bus.flush = 0;
    cmp_en = 1;
    bus.start = 1; bus.flush = 1;
    tick(); tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_parallel_out", bus.regs_parallel_out, 0);
    chk("rst_shift_en", bus.reg_shift_en, 0);
    rstn = 1; bus.start = 1; bus.flush = 1;
    tick();
    bus.start = 0; bus.flush = 0;
    chk("flush_beats_start", bus.busy, 0);
    snap(); op(8'h4D, 1, 0);
    deltas("wb1", 8, 1, 1);
    chk("wb1_word", bus.regs_parallel_out, 8'h4D);
    chk("model_word", m_acc, 8'h4D);
    chk("wb1_idle", bus.busy, 0);
    snap(); op(8'h4D, 0, 0);
    deltas("wb0", 8, 0, 1);
    chk("wb0_word", bus.regs_parallel_out, 8'h4D);
    snap(); op(8'h3C, 1, 1);
    deltas("stray", 8, 1, 1);
    chk("stray_word", bus.regs_parallel_out, 8'h3C);
    tick();
    chk("stray_not_queued", bus.busy, 0);
    snap(); op(8'hF0, 1, 2);
    deltas("flush", 5, 0, 0);
    chk("flush_idle", bus.busy, 0);
    chk("flush_count", bus.bit_count, 0);
    snap(); op(8'h96, 1, 0);
    deltas("after_flush", 8, 1, 1);
    chk("after_flush_word", bus.regs_parallel_out, 8'h96);
    snap(); op(8'h5A, 1, 3);
    deltas("rst_store", 8, 0, 0);
    chk("rst_store_acc", bus.regs_parallel_out, 0);
    chk("rst_store_busy", bus.busy, 0);
    snap(); op(8'h4D, 1, 0);
    deltas("post_rst", 8, 1, 1);
    chk("post_rst_word", bus.regs_parallel_out, 8'h4D);
    snap();
    op(8'hFF, 1, 0); chk("b2b_ff", bus.regs_parallel_out, 8'hFF);
    op(8'h00, 1, 0); chk("b2b_00", bus.regs_parallel_out, 8'h00);
    op(8'hA5, 1, 0); chk("b2b_a5", bus.regs_parallel_out, 8'hA5);
    deltas("b2b", 24, 3, 3);
    if (dt.size() >= 3) begin
      chk("period_1", dt[dt.size()-2] - dt[dt.size()-3], 11);
      chk("period_2", dt[dt.size()-1] - dt[dt.size()-2], 11);
    end else chk("done_pulses", dt.size(), 3);
    chk("no_overlap", ovl_n, 0);
    tick();
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
